// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver FSM states and the baud divider math.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK_WAIT
    } rx_state_e;

    // Clocks per oversample tick, shared with the transmitter so both ends agree on the rate.
    function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
        return clk_freq / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: one-cycle tick every DIV clocks, realignable by restart_i.
module uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic restart_i,
    output logic tick_o
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A restart swallows any tick due in the same cycle so the new frame starts a full period.
    assign tick_o = (cnt_q == LAST) && !restart_i;

endmodule

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver: majority-voted bit recovery feeding the rx FIFO write port,
// with framing, parity, overrun and break reported as single-cycle pulses.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rx,
    output logic       o_wen,
    output logic [7:0] o_wdata,
    input  logic       i_full,
    output logic       o_busy,
    output logic       o_frame_err,
    output logic       o_parity_err,
    output logic       o_overrun,
    output logic       o_break
);

    localparam int             DIV      = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int             SCW      = $clog2(OVERSAMPLE);
    localparam logic [SCW-1:0] S_LAST   = SCW'(OVERSAMPLE - 1);
    localparam logic [SCW-1:0] S_FIRST  = SCW'(OVERSAMPLE / 2 - 1);
    localparam logic [SCW-1:0] S_THIRD  = SCW'(OVERSAMPLE / 2 + 1);
    localparam logic [3:0]     BIT_LAST = 4'(DATA_BITS - 1);

    logic                 rx_meta_q, rx_sync_q, rx_prev_q;
    logic                 start_edge;
    logic                 tick;
    logic [SCW-1:0]       smp_cnt_q;
    logic [2:0]           votes_q;
    logic                 vote_q;
    logic                 bit_val;
    logic                 par_ok;
    rx_state_e            state_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [3:0]           bit_cnt_q;
    logic                 par_bit_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= i_rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    assign start_edge = (state_q == RX_IDLE) && rx_prev_q && !rx_sync_q;

    uart_baud_tick #(
        .DIV(DIV)
    ) u_tick (
        .clk_i    (clk),
        .rst_i    (rst),
        .restart_i(start_edge),
        .tick_o   (tick)
    );

    // Three samples around mid-bit; vote_q flags the cycle after the last one so the FSM acts on it.
    always_ff @(posedge clk) begin
        if (rst || start_edge) begin
            smp_cnt_q <= '0;
            votes_q   <= '0;
            vote_q    <= 1'b0;
        end else begin
            vote_q <= 1'b0;
            if (tick) begin
                smp_cnt_q <= (smp_cnt_q == S_LAST) ? '0 : smp_cnt_q + 1'b1;
                if ((smp_cnt_q >= S_FIRST) && (smp_cnt_q <= S_THIRD)) begin
                    votes_q <= {votes_q[1:0], rx_sync_q};
                end
                if (smp_cnt_q == S_THIRD) begin
                    vote_q <= 1'b1;
                end
            end
        end
    end

    assign bit_val = (votes_q[0] & votes_q[1]) | (votes_q[0] & votes_q[2]) | (votes_q[1] & votes_q[2]);

    assign par_ok = (PARITY == PAR_ODD)  ?  ((^shift_q) ^ par_bit_q) :
                    (PARITY == PAR_EVEN) ? !((^shift_q) ^ par_bit_q) : 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RX_IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            par_bit_q    <= 1'b0;
            o_wen        <= 1'b0;
            o_wdata      <= '0;
            o_busy       <= 1'b0;
            o_frame_err  <= 1'b0;
            o_parity_err <= 1'b0;
            o_overrun    <= 1'b0;
            o_break      <= 1'b0;
        end else begin
            o_wen        <= 1'b0;
            o_frame_err  <= 1'b0;
            o_parity_err <= 1'b0;
            o_overrun    <= 1'b0;
            o_break      <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    if (start_edge) begin
                        state_q <= RX_START;
                        o_busy  <= 1'b1;
                    end
                end
                RX_START: begin
                    if (vote_q) begin
                        if (bit_val) begin
                            state_q <= RX_IDLE;
                            o_busy  <= 1'b0;
                        end else begin
                            state_q   <= RX_DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                end
                RX_DATA: begin
                    if (vote_q) begin
                        shift_q <= {bit_val, shift_q[DATA_BITS-1:1]};
                        if (bit_cnt_q == BIT_LAST) begin
                            state_q <= (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                RX_PARITY: begin
                    if (vote_q) begin
                        par_bit_q <= bit_val;
                        state_q   <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    // Leaving at mid stop bit gives half a bit of slack before a back-to-back start edge.
                    if (vote_q) begin
                        if (bit_val) begin
                            if (i_full) begin
                                o_overrun <= 1'b1;
                            end else begin
                                o_wen        <= 1'b1;
                                o_wdata      <= 8'(shift_q);
                                o_parity_err <= !par_ok;
                            end
                            state_q <= RX_IDLE;
                            o_busy  <= 1'b0;
                        end else if ((shift_q == '0) && par_ok) begin
                            o_break <= 1'b1;
                            state_q <= RX_BREAK_WAIT;
                        end else begin
                            o_frame_err <= 1'b1;
                            state_q     <= RX_IDLE;
                            o_busy      <= 1'b0;
                        end
                    end
                end
                RX_BREAK_WAIT: begin
                    if (rx_sync_q) begin
                        state_q <= RX_IDLE;
                        o_busy  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= RX_IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: an 8N1 instance and an 8E1 instance, driven from a vector table,
// hand-written corner sequences and random frames checked against a frame-level model.
module tb_uart_rx_core;

    localparam int BIT_CLKS = 50;

    typedef struct {
        int         wen;
        logic [7:0] data;
        int         frame;
        int         par;
        int         ovr;
        int         brk;
    } exp_t;

    typedef struct {
        int         dutSel;
        logic [7:0] data;
        logic       parBit;
        logic       stopBit;
        logic       full;
        int         gapBits;
        int         expWen;
        logic [7:0] expData;
        int         expFrame;
        int         expPar;
        int         expOvr;
        int         expBrk;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] rxLine, fullLine;
    logic [1:0] wen, busy, frameErr, parErr, ovr, brk;
    logic [7:0] wdata0, wdata1;

    int         wenCnt[2], frameCnt[2], parCnt[2], ovrCnt[2], brkCnt[2];
    logic [7:0] lastData[2];
    int         checks = 0;
    int         errors = 0;
    vec_t       vecs[10];

    always #5 clk = ~clk;

    uart_rx_core #(
        .CLK_FREQ(50_000_000), .BAUD(1_000_000), .OVERSAMPLE(10), .DATA_BITS(8), .PARITY(0)
    ) dutNone (
        .clk(clk), .rst(rst), .i_rx(rxLine[0]), .o_wen(wen[0]), .o_wdata(wdata0),
        .i_full(fullLine[0]), .o_busy(busy[0]), .o_frame_err(frameErr[0]),
        .o_parity_err(parErr[0]), .o_overrun(ovr[0]), .o_break(brk[0])
    );

    uart_rx_core #(
        .CLK_FREQ(50_000_000), .BAUD(1_000_000), .OVERSAMPLE(10), .DATA_BITS(8), .PARITY(2)
    ) dutEven (
        .clk(clk), .rst(rst), .i_rx(rxLine[1]), .o_wen(wen[1]), .o_wdata(wdata1),
        .i_full(fullLine[1]), .o_busy(busy[1]), .o_frame_err(frameErr[1]),
        .o_parity_err(parErr[1]), .o_overrun(ovr[1]), .o_break(brk[1])
    );

    // Counting high cycles rather than edges makes a stretched pulse show up as a wrong count.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (wen[i] === 1'b1) begin
                wenCnt[i]++;
                lastData[i] = (i == 0) ? wdata0 : wdata1;
            end
            if (frameErr[i] === 1'b1) frameCnt[i]++;
            if (parErr[i] === 1'b1)   parCnt[i]++;
            if (ovr[i] === 1'b1)      ovrCnt[i]++;
            if (brk[i] === 1'b1)      brkCnt[i]++;
        end
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic waitClks(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic checkVal(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t refModel(input int parMode, input logic [7:0] d, input logic pb,
                                      input logic stopBit, input logic full);
        exp_t e;
        int   ones;
        bit   parityOk;
        e    = '{0, 8'h00, 0, 0, 0, 0};
        ones = $countones(d) + int'(pb);
        if (parMode == 0)      parityOk = 1'b1;
        else if (parMode == 1) parityOk = (ones % 2) == 1;
        else                   parityOk = (ones % 2) == 0;
        if (stopBit) begin
            if (full) begin
                e.ovr = 1;
            end else begin
                e.wen  = 1;
                e.data = d;
                e.par  = parityOk ? 0 : 1;
            end
        end else if (d == 8'h00 && parityOk) begin
            e.brk = 1;
        end else begin
            e.frame = 1;
        end
        return e;
    endfunction

    task automatic clearCounts();
        for (int i = 0; i < 2; i++) begin
            wenCnt[i] = 0; frameCnt[i] = 0; parCnt[i] = 0; ovrCnt[i] = 0; brkCnt[i] = 0;
        end
    endtask

    // Serial frame onto one line; the parity bit is only sent to the even-parity instance.
    task automatic applyStimulus(input int sel, input logic [7:0] d, input logic pb,
                                 input logic stopBit, input logic full, input int gapBits);
        fullLine[sel] = full;
        rxLine[sel]   = 1'b1;
        waitClks(gapBits * BIT_CLKS);
        rxLine[sel] = 1'b0;
        waitClks(BIT_CLKS);
        for (int b = 0; b < 8; b++) begin
            rxLine[sel] = d[b];
            waitClks(BIT_CLKS);
        end
        if (sel == 1) begin
            rxLine[sel] = pb;
            waitClks(BIT_CLKS);
        end
        rxLine[sel] = stopBit;
        waitClks(BIT_CLKS);
        rxLine[sel]   = 1'b1;
        fullLine[sel] = 1'b0;
    endtask

    task automatic checkOutput(input int sel, input exp_t e, input string tag);
        int other;
        other = 1 - sel;
        checkVal({tag, ".wen"}, wenCnt[sel], e.wen);
        if (e.wen > 0) checkVal({tag, ".wdata"}, int'(lastData[sel]), int'(e.data));
        checkVal({tag, ".frameErr"}, frameCnt[sel], e.frame);
        checkVal({tag, ".parityErr"}, parCnt[sel], e.par);
        checkVal({tag, ".overrun"}, ovrCnt[sel], e.ovr);
        checkVal({tag, ".break"}, brkCnt[sel], e.brk);
        checkVal({tag, ".otherQuiet"},
                 wenCnt[other] + frameCnt[other] + parCnt[other] + ovrCnt[other] + brkCnt[other], 0);
        clearCounts();
    endtask

    initial begin
        exp_t       e;
        exp_t       none;
        logic [7:0] d;
        logic       pb, stopBit, full;
        int         sel, gap;
        logic       prevStop;
        int         prevSel;

        none = '{0, 8'h00, 0, 0, 0, 0};

        //            dut data   pb    st    full  gap wen data  fr par ovr brk
        vecs[0] = '{0, 8'hA5, 1'b0, 1'b1, 1'b0, 2,  1, 8'hA5, 0, 0,  0,  0};
        vecs[1] = '{0, 8'h3C, 1'b0, 1'b1, 1'b0, 0,  1, 8'h3C, 0, 0,  0,  0};
        vecs[2] = '{0, 8'h3C, 1'b0, 1'b0, 1'b0, 2,  0, 8'h00, 1, 0,  0,  0};
        vecs[3] = '{0, 8'h55, 1'b0, 1'b1, 1'b0, 2,  1, 8'h55, 0, 0,  0,  0};
        vecs[4] = '{1, 8'h01, 1'b0, 1'b1, 1'b0, 2,  1, 8'h01, 0, 1,  0,  0};
        vecs[5] = '{1, 8'h01, 1'b1, 1'b1, 1'b0, 2,  1, 8'h01, 0, 0,  0,  0};
        vecs[6] = '{0, 8'h7E, 1'b0, 1'b1, 1'b1, 2,  0, 8'h00, 0, 0,  1,  0};
        vecs[7] = '{1, 8'h00, 1'b0, 1'b0, 1'b0, 2,  0, 8'h00, 0, 0,  0,  1};
        vecs[8] = '{1, 8'h3C, 1'b1, 1'b0, 1'b0, 2,  0, 8'h00, 1, 0,  0,  0};
        vecs[9] = '{1, 8'h00, 1'b1, 1'b0, 1'b0, 2,  0, 8'h00, 1, 0,  0,  0};

        rst      = 1'b1;
        rxLine   = 2'b11;
        fullLine = 2'b00;
        clearCounts();
        waitClks(5);
        checkVal("reset.wen", int'(wen), 0);
        checkVal("reset.busy", int'(busy), 0);
        checkVal("reset.pulses", int'(frameErr | parErr | ovr | brk), 0);
        checkVal("reset.wdata0", int'(wdata0), 0);
        checkVal("reset.wdata1", int'(wdata1), 0);
        rst = 1'b0;
        waitClks(10);
        checkVal("idle.busy", int'(busy), 0);
        clearCounts();

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].dutSel, vecs[i].data, vecs[i].parBit, vecs[i].stopBit,
                          vecs[i].full, vecs[i].gapBits);
            e = '{vecs[i].expWen, vecs[i].expData, vecs[i].expFrame, vecs[i].expPar,
                  vecs[i].expOvr, vecs[i].expBrk};
            checkOutput(vecs[i].dutSel, e, $sformatf("vec%0d", i));
        end
        waitClks(BIT_CLKS);
        checkVal("hold.wdata0", int'(wdata0), 8'h55);
        checkVal("hold.wdata1", int'(wdata1), 8'h01);

        // Short low glitch must be rejected as a false start.
        rxLine[0] = 1'b0;
        waitClks(10);
        checkVal("glitch.busyHigh", int'(busy[0]), 1);
        waitClks(5);
        rxLine[0] = 1'b1;
        waitClks(35);
        checkVal("glitch.busyLow", int'(busy[0]), 0);
        waitClks(BIT_CLKS);
        checkOutput(0, none, "glitch");

        // Line held low for 12 bit times, then released.
        rxLine[0] = 1'b0;
        waitClks(12 * BIT_CLKS);
        checkVal("break.busyHeld", int'(busy[0]), 1);
        rxLine[0] = 1'b1;
        waitClks(2 * BIT_CLKS);
        checkVal("break.busyReleased", int'(busy[0]), 0);
        checkOutput(0, '{0, 8'h00, 0, 0, 0, 1}, "break");
        applyStimulus(0, 8'h55, 1'b0, 1'b1, 1'b0, 1);
        checkOutput(0, '{1, 8'h55, 0, 0, 0, 0}, "afterBreak");

        // Reset in the middle of data bit 3 abandons the frame without any pulse.
        d = 8'hC3;
        rxLine[0] = 1'b0;
        waitClks(BIT_CLKS);
        for (int b = 0; b < 3; b++) begin
            rxLine[0] = d[b];
            waitClks(BIT_CLKS);
        end
        rxLine[0] = d[3];
        waitClks(20);
        checkVal("midReset.busyBefore", int'(busy[0]), 1);
        rst       = 1'b1;
        rxLine[0] = 1'b1;
        waitClks(1);
        rst = 1'b0;
        waitClks(2 * BIT_CLKS);
        checkVal("midReset.busyAfter", int'(busy[0]), 0);
        checkOutput(0, none, "midReset");
        applyStimulus(0, 8'h81, 1'b0, 1'b1, 1'b0, 1);
        checkOutput(0, '{1, 8'h81, 0, 0, 0, 0}, "afterReset");

        prevStop = 1'b1;
        prevSel  = 0;
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 1);
            d   = 8'($urandom);
            if ($urandom_range(0, 7) == 0) d = 8'h00;
            pb = 1'($countones(d) % 2);
            if ($urandom_range(0, 3) == 0) pb = ~pb;
            stopBit = ($urandom_range(0, 5) != 0);
            full    = ($urandom_range(0, 6) == 0);
            gap     = $urandom_range(0, 2);
            if (gap == 0 && sel == prevSel && !prevStop) gap = 1;
            applyStimulus(sel, d, pb, stopBit, full, gap);
            e = refModel((sel == 1) ? 2 : 0, d, pb, stopBit, full);
            checkOutput(sel, e, $sformatf("rand%0d", n));
            prevStop = stopBit;
            prevSel  = sel;
        end

        waitClks(2 * BIT_CLKS);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
